// File: rtl/bcd_para_bin_pkg.sv
// Shared conversion constants for the BCD-to-binary converter:
// default digit count, result width and FSM state encoding.
package bcd_para_bin_pkg;

  localparam int N_DIGITS_DEF = 8;
  localparam int BIN_W_DEF    = 27;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_para_bin_if.sv
// Request/result bundle of the BCD-to-binary converter; the requester
// drives start/bcd_in, the converter returns busy/done/bin_out/err.
interface bcd_para_bin_if
  import bcd_para_bin_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int BIN_W    = BIN_W_DEF
);

  logic                  start;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_corr.sv
// One reverse double-dabble digit correction: after the right shift a
// digit of 8 or more carried in a half-weight 10, so 3 is taken off.
module bcd_digit_corr (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
  end

endmodule

// File: rtl/bcd_para_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble),
// one bit per cycle, BIN_W iterations per accepted request.
module bcd_para_bin
  import bcd_para_bin_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int BIN_W    = BIN_W_DEF
)(
  input  logic           clock,
  input  logic           reset,
  bcd_para_bin_if.slave  bus
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  state_t               state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]     bin_out_q, bin_out_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [BCD_W+BIN_W-1:0] cat_sh;
  logic [BCD_W-1:0]       bcd_sh;
  logic [BIN_W-1:0]       bin_sh;
  logic [BCD_W-1:0]       bcd_corr;
  logic                   bad_digit;
  logic                   accept;
  logic                   last_it;

  assign cat_sh  = {bcd_q, bin_q} >> 1;
  assign bcd_sh  = cat_sh[BCD_W+BIN_W-1:BIN_W];
  assign bin_sh  = cat_sh[BIN_W-1:0];
  assign accept  = (state_q == IDLE) && bus.start;
  assign last_it = (cnt_q == LAST_IT);

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit_i (bcd_sh[4*i +: 4]),
      .digit_o (bcd_corr[4*i +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Invalid requests never enter CONV; they are answered from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && !bad_digit) state_d = CONV;
      CONV: if (last_it)              state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // The final iteration writes its shifted value straight to bin_out so
  // that done and the falling edge of busy land on the same cycle.
  always_comb begin
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    if (accept) begin
      bcd_d = bus.bcd_in;
      bin_d = '0;
      cnt_d = '0;
      err_d = bad_digit;
      if (bad_digit) begin
        bin_out_d = '0;
        done_d    = 1'b1;
      end
    end else if (state_q == CONV) begin
      bcd_d = bcd_corr;
      bin_d = bin_sh;
      cnt_d = cnt_q + 1'b1;
      if (last_it) begin
        bin_out_d = bin_sh;
        done_d    = 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy    = (state_q == CONV);
    bus.done    = done_q;
    bus.bin_out = bin_out_q;
    bus.err     = err_q;
  end

endmodule
